// File: rtl/comb_truth_table_scanner_if.sv
// Handshake and probe bundle between the board controller / comb block and the truth-table scanner.
// Latency: none, wires only.
// Backpressure: none; start is a level request and the scanner ignores it while it is not idle.
//
// Signals:
//   i_w_start  scan request (controller -> scanner)
//   i_w_out    comb block output (comb -> scanner)
//   o_w_a/b/c  drives to the comb block inputs (scanner -> comb)
//   o_w_index  current combination index {a,b,c}
//   o_w_busy   scan in progress
//   o_w_done   one-cycle completion pulse
//   o_w_table  assembled truth table, bit i = comb output for {a,b,c}=i
interface comb_truth_table_scanner_if;
    logic       i_w_start;
    logic       i_w_out;
    logic       o_w_a;
    logic       o_w_b;
    logic       o_w_c;
    logic [2:0] o_w_index;
    logic       o_w_busy;
    logic       o_w_done;
    logic [7:0] o_w_table;

    // Controller / comb side: supplies start and the comb result, observes everything else.
    modport master (
        output i_w_start,
        output i_w_out,
        input  o_w_a,
        input  o_w_b,
        input  o_w_c,
        input  o_w_index,
        input  o_w_busy,
        input  o_w_done,
        input  o_w_table
    );

    // Scanner side.
    modport slave (
        input  i_w_start,
        input  i_w_out,
        output o_w_a,
        output o_w_b,
        output o_w_c,
        output o_w_index,
        output o_w_busy,
        output o_w_done,
        output o_w_table
    );
endinterface

// File: rtl/comb_truth_table_scanner.sv
// Steps a 3-input comb block through all 8 input combinations (a outer, c inner) and builds its truth table.
// Latency: busy for 8*(SETTLE_CYCLES+1) cycles after the accepting edge, then a one-cycle done pulse.
// Backpressure: none; start is only sampled in IDLE and ignored while busy or during the done cycle.
//
// Ports:
//   i_w_clk    system clock, rising edge
//   i_w_reset  synchronous active-high reset; abandons any scan and clears the table
//   bus        slave side of comb_truth_table_scanner_if (start, comb output, drives, index, busy, done, table)
//
// Parameter SETTLE_CYCLES (1..255): cycles each combination is held before the sampling cycle.
module comb_truth_table_scanner #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                          i_w_clk,
    input  logic                          i_w_reset,
    comb_truth_table_scanner_if.slave     bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Terminal value of the 8-bit settle counter.
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q,   cnt_d;
    logic [2:0] index_q, index_d;
    logic [7:0] table_q, table_d;
    logic       busy_q,  busy_d;
    logic       done_q,  done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        index_d = index_q;
        table_d = table_q;

        case (state_q)
            ST_IDLE: begin
                index_d = 3'd0;
                if (bus.i_w_start) begin
                    // A new scan discards the previous table at acceptance.
                    table_d = 8'h00;
                    cnt_d   = 8'd0;
                    state_d = ST_SETTLE;
                end
            end

            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = 8'd0;
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            ST_SAMPLE: begin
                table_d[index_q] = bus.i_w_out;
                if (index_q == 3'd7) begin
                    // Return the index to 0 on entry to DONE so the comb drives are already low there.
                    index_d = 3'd0;
                    state_d = ST_DONE;
                end else begin
                    index_d = index_q + 3'd1;
                    state_d = ST_SETTLE;
                end
            end

            ST_DONE: begin
                index_d = 3'd0;
                state_d = ST_IDLE;
            end

            default: begin
                index_d = 3'd0;
                cnt_d   = 8'd0;
                state_d = ST_IDLE;
            end
        endcase

        // Status flags are registered from the next state so they line up with the state they describe.
        busy_d = (state_d == ST_SETTLE) || (state_d == ST_SAMPLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge i_w_clk) begin
        if (i_w_reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            index_q <= 3'd0;
            table_q <= 8'h00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            index_q <= index_d;
            table_q <= table_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.o_w_index = index_q;
    assign bus.o_w_a     = index_q[2];
    assign bus.o_w_b     = index_q[1];
    assign bus.o_w_c     = index_q[0];
    assign bus.o_w_busy  = busy_q;
    assign bus.o_w_done  = done_q;
    assign bus.o_w_table = table_q;

endmodule

// File: tb/tb_comb_truth_table_scanner.sv
module tb_comb_truth_table_scanner;

    localparam int MODE_AND = 0;
    localparam int MODE_XOR = 1;
    localparam int MODE_MAJ = 2;

    logic clk;
    logic rst;
    int   mode0;
    int   mode1;
    bit   mon_en;

    int tests;
    int fails;

    // Scoreboard queues: expected table for each issued scan, popped at every done pulse.
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    comb_truth_table_scanner_if bus0 ();
    comb_truth_table_scanner_if bus1 ();

    comb_truth_table_scanner #(.SETTLE_CYCLES(1)) u_dut0 (
        .i_w_clk   (clk),
        .i_w_reset (rst),
        .bus       (bus0.slave)
    );

    comb_truth_table_scanner #(.SETTLE_CYCLES(3)) u_dut1 (
        .i_w_clk   (clk),
        .i_w_reset (rst),
        .bus       (bus1.slave)
    );

    function automatic logic comb_model(input int mode, input logic a, input logic b, input logic c);
        case (mode)
            MODE_AND: return a & b & c;
            MODE_XOR: return a ^ b ^ c;
            default:  return (a & b) | (a & c) | (b & c);
        endcase
    endfunction

    assign bus0.i_w_out = comb_model(mode0, bus0.o_w_a, bus0.o_w_b, bus0.o_w_c);
    assign bus1.i_w_out = comb_model(mode1, bus1.o_w_a, bus1.o_w_b, bus1.o_w_c);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-DUT views for the shared monitor.
    logic       busy [2];
    logic       done [2];
    logic [2:0] idx  [2];
    logic [2:0] abc  [2];
    logic [7:0] tbl  [2];
    always_comb begin
        busy[0] = bus0.o_w_busy;  busy[1] = bus1.o_w_busy;
        done[0] = bus0.o_w_done;  done[1] = bus1.o_w_done;
        idx[0]  = bus0.o_w_index; idx[1]  = bus1.o_w_index;
        tbl[0]  = bus0.o_w_table; tbl[1]  = bus1.o_w_table;
        abc[0]  = {bus0.o_w_a, bus0.o_w_b, bus0.o_w_c};
        abc[1]  = {bus1.o_w_a, bus1.o_w_b, bus1.o_w_c};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    int  settle [2] = '{1, 3};
    int  blen   [2] = '{0, 0};
    bit  berr   [2] = '{0, 0};
    bit  bprev  [2] = '{0, 0};
    bit  dprev  [2] = '{0, 0};
    bit  abort  [2] = '{0, 0};

    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < 2; d++) begin
                logic [7:0] exp_t;
                check($sformatf("abc_vs_index%0d", d), {29'd0, abc[d]}, {29'd0, idx[d]});
                if (!busy[d] && !rst)
                    check($sformatf("idle_index%0d", d), {29'd0, idx[d]}, 32'd0);

                if (busy[d]) begin
                    // Each index must be held for exactly settle+1 cycles, in ascending order.
                    if (idx[d] != 3'(blen[d] / (settle[d] + 1)))
                        berr[d] = 1'b1;
                    blen[d]++;
                end else if (bprev[d]) begin
                    if (abort[d]) begin
                        abort[d] = 1'b0;
                    end else begin
                        check($sformatf("busy_len%0d", d), blen[d], 8 * (settle[d] + 1));
                        check($sformatf("index_seq%0d", d), {31'd0, berr[d]}, 32'd0);
                    end
                    blen[d] = 0;
                    berr[d] = 1'b0;
                end
                bprev[d] = busy[d];

                if (done[d]) begin
                    check($sformatf("done_single%0d", d), {31'd0, dprev[d]}, 32'd0);
                    check($sformatf("done_busy_low%0d", d), {31'd0, busy[d]}, 32'd0);
                    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                        check($sformatf("unexpected_done%0d", d), 32'd1, 32'd0);
                    end else begin
                        exp_t = (d == 0) ? q0.pop_front() : q1.pop_front();
                        check($sformatf("table%0d", d), {24'd0, tbl[d]}, {24'd0, exp_t});
                    end
                end
                dprev[d] = done[d];
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_start(input int d, input logic v);
        if (d == 0) bus0.i_w_start = v;
        else        bus1.i_w_start = v;
    endtask

    task automatic pulse_start(input int d);
        @(negedge clk);
        set_start(d, 1'b1);
        @(negedge clk);
        set_start(d, 1'b0);
    endtask

    task automatic wait_done(input int d, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done[d] && n < budget);
        if (!done[d]) check($sformatf("done_timeout%0d", d), 32'd1, 32'd0);
    endtask

    task automatic wait_index(input int d, input logic [2:0] v, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (idx[d] != v && n < budget);
        if (idx[d] != v) check($sformatf("index_timeout%0d", d), 32'd1, 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        tests          = 0;
        fails          = 0;
        mon_en         = 1'b0;
        rst            = 1'b1;
        mode0          = MODE_AND;
        mode1          = MODE_XOR;
        bus0.i_w_start = 1'b0;
        bus1.i_w_start = 1'b0;
        repeat (3) @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Idle after reset: everything quiet.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle0", {busy[0], done[0], tbl[0], abc[0]}, 32'd0);
            check("idle1", {busy[1], done[1], tbl[1], abc[1]}, 32'd0);
        end

        // AND3, settle 1.
        mode0 = MODE_AND;
        q0.push_back(8'h80);
        pulse_start(0);
        check("busy_after_start0", {31'd0, busy[0]}, 32'd1);
        wait_done(0, 40);
        repeat (5) @(negedge clk);
        check("table_hold0", {24'd0, tbl[0]}, 32'h80);

        // XOR3 then majority, settle 3; second start clears the table.
        mode1 = MODE_XOR;
        q1.push_back(8'h96);
        pulse_start(1);
        wait_done(1, 80);
        @(negedge clk);
        mode1 = MODE_MAJ;
        q1.push_back(8'hE8);
        pulse_start(1);
        check("table_cleared1", {24'd0, tbl[1]}, 32'h00);
        check("busy_major1", {31'd0, busy[1]}, 32'd1);
        wait_done(1, 80);

        // Starts while busy and during the done cycle are ignored.
        mode0 = MODE_XOR;
        q0.push_back(8'h96);
        pulse_start(0);
        wait_index(0, 3'd4, 40);
        pulse_start(0);
        wait_done(0, 40);
        set_start(0, 1'b1);
        @(negedge clk);
        set_start(0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("ignored_start_busy0", {31'd0, busy[0]}, 32'd0);
        end
        check("table_after_ignored0", {24'd0, tbl[0]}, 32'h96);

        // Reset mid-scan at index 5 (first cycle at index 5 is SETTLE).
        mode0 = MODE_AND;
        q0.push_back(8'h80);
        pulse_start(0);
        wait_index(0, 3'd5, 40);
        abort[0] = 1'b1;
        q0.delete();
        rst = 1'b1;
        @(negedge clk);
        check("abort_state0", {busy[0], done[0], tbl[0], idx[0]}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        mode0 = MODE_MAJ;
        q0.push_back(8'hE8);
        pulse_start(0);
        wait_done(0, 40);

        // Start held high: back-to-back scans with one IDLE cycle in between.
        mode1 = MODE_XOR;
        q1.push_back(8'h96);
        q1.push_back(8'h96);
        q1.push_back(8'h96);
        @(negedge clk);
        set_start(1, 1'b1);
        for (int s = 0; s < 2; s++) begin
            wait_done(1, 80);
            @(negedge clk);
            check("gap_idle1", {busy[1], done[1]}, 32'd0);
            @(negedge clk);
            check("gap_rebusy1", {31'd0, busy[1]}, 32'd1);
            check("gap_cleared1", {24'd0, tbl[1]}, 32'h00);
        end
        set_start(1, 1'b0);
        wait_done(1, 80);
        repeat (4) @(negedge clk);
        check("busy_final1", {31'd0, busy[1]}, 32'd0);

        check("scoreboard_empty0", q0.size(), 32'd0);
        check("scoreboard_empty1", q1.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/comb_truth_table_scanner.md
Name: comb_truth_table_scanner

Overview:
Sequencer that sits on both sides of the 3-input combinational `comb` block. It drives `comb`'s a/b/c inputs through all 8 combinations in the same order as the directed bench loop (a outer, c inner). It samples `comb`'s output for each combination and assembles an 8-bit truth table. The table lets the lab board self-check a student `comb` implementation in hardware, with no simulator. It exposes a simple start/busy/done handshake to the board controller.

Parameters:
SETTLE_CYCLES, 1, cycles each combination is held before the output is sampled; legal range 1..255 (8-bit settle counter)

Ports:
i_w_clk  input  1  system clock, all logic on rising edge
i_w_reset  input  1  synchronous active-high reset
i_w_start  input  1  scan request, sampled only in IDLE
o_w_a  output  1  drive to comb i_w_a (index bit 2)
o_w_b  output  1  drive to comb i_w_b (index bit 1)
o_w_c  output  1  drive to comb i_w_c (index bit 0)
i_w_out  input  1  comb o_w_out, sampled in SAMPLE state
o_w_index  output  3  current combination index {a,b,c}
o_w_busy  output  1  high while scanning (SETTLE or SAMPLE)
o_w_done  output  1  one-cycle pulse; table complete
o_w_table  output  8  truth table; bit i = comb output for {a,b,c}=i

Behaviour:
- Reset (synchronous, active-high):
  - Every output is 0: index, a/b/c, busy, done, table.
  - State goes to IDLE and the settle counter goes to 0.
  - Reset wins over all other events, including mid-scan. A scan in progress is abandoned and its partial table is discarded.
- o_w_a/o_w_b/o_w_c are o_w_index[2]/[1]/[0] combinationally from the registered index. They are 0 in IDLE and DONE.
- States and transitions:
  - IDLE: busy=0, done=0, index=0. If i_w_start=1 at the edge: table<=0, index<=0, cnt<=0, go to SETTLE.
  - SETTLE: busy=1. cnt increments each cycle. When cnt==SETTLE_CYCLES-1: cnt<=0 and go to SAMPLE.
  - SAMPLE: busy=1. At the edge, table[index]<=i_w_out.
    - If index==7: go to DONE.
    - Otherwise index<=index+1 and go to SETTLE.
  - DONE: busy=0, done=1 for exactly one cycle, index<=0, then unconditionally go to IDLE.
- Hold time per combination: exactly SETTLE_CYCLES+1 cycles (SETTLE_CYCLES in SETTLE plus 1 in SAMPLE). The output is sampled at the end of the last held cycle.
- Latency:
  - Start is seen at edge k; busy rises after edge k.
  - Busy stays high for exactly 8*(SETTLE_CYCLES+1) cycles.
  - done is high in the following cycle.
  - o_w_table is final and valid from the done cycle onward.
- o_w_table holds its value after DONE until the next accepted start (cleared at that start) or reset.
- i_w_start is ignored when not in IDLE (busy or DONE cycle). A start held high continuously re-triggers a new scan one cycle after DONE.
- Index wrap: no wrap. The scan terminates at index 7 and the index returns to 0 only via DONE or reset.
- i_w_out is sampled only in SAMPLE; its value in other states has no effect.

Test Plan:
- Reset then idle, start=0 for 20 cycles -> busy=0, done=0, table=8'h00, a/b/c=0 throughout.
- Bench models comb as 3-input AND, SETTLE_CYCLES=1, one-cycle start pulse -> busy high 16 cycles, {a,b,c} steps 0..7 with each value held 2 cycles, done pulses once, table=8'h80.
- Model XOR3, then majority, SETTLE_CYCLES=3 -> busy high 32 cycles, tables 8'h96 then 8'hE8. The second start clears the table to 8'h00 at acceptance.
- Start pulsed again while busy (at index 4) and during the done cycle -> ignored; scan completes unchanged with a single done pulse.
- Reset asserted while index=5 in SETTLE -> next cycle busy=0, table=8'h00, index=0, no done pulse. A new start performs a full, correct scan.
- Start held high permanently with XOR3 -> back-to-back scans with exactly one IDLE cycle between done and the next busy rise; table=8'h96 at each done.
